// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - calculator keystroke sequencer with serial BCD add/sub and display sweep
//
// Accepts digit/operator commands, keeps an 8-digit BCD entry buffer and the
// pending operation, evaluates add/subtract one digit per cycle, and rewrites
// all 8 display digits (one position per cycle) after every visible change.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   cmd_valid  command strobe, taken only while cmd_ready
//   cmd[3:0]   0-9 digit, 10 add, 11 sub, 14 equals, 15 clear, 12/13 ignored
//   cmd_ready  high only while idle
//   wr_en      display write strobe
//   wr_pos     display position, 0 = least significant
//   wr_dig     BCD digit for wr_pos
//   neg        last result was negative (magnitude displayed)
//   err        add overflow latched until clear
module calc_seq (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [3:0] cmd,
  output logic       cmd_ready,
  output logic       wr_en,
  output logic [3:0] wr_pos,
  output logic [3:0] wr_dig,
  output logic       neg,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_REFRESH, S_CALC, S_CALC2} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB} op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fresh_q, fresh_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic        cy_q, cy_d;

  // Digit ALU operands: CALC does opa op b, CALC2 does b - opa.
  logic [3:0]  alu_x, alu_y, alu_dig;
  logic [4:0]  alu_raw;
  logic        alu_sub, alu_cy;
  logic [4:0]  nib;

  // Entry buffer as seen by a digit key: a fresh number starts from zero.
  logic [31:0] buf_eff;
  logic [3:0]  cnt_eff;

  assign nib     = {idx_q, 2'b00};
  assign buf_eff = fresh_q ? 32'd0 : buf_q;
  assign cnt_eff = fresh_q ? 4'd0  : cnt_q;

  always_comb begin
    alu_sub = (state_q == S_CALC2) || (op_q == OP_SUB);
    if (state_q == S_CALC2) begin
      alu_x = b_q[nib +: 4];
      alu_y = opa_q[nib +: 4];
    end else begin
      alu_x = opa_q[nib +: 4];
      alu_y = b_q[nib +: 4];
    end
    if (alu_sub) begin
      alu_raw = {1'b0, alu_x} - {1'b0, alu_y} - {4'd0, cy_q};
      alu_cy  = alu_raw[4];
      // Low nibble plus 10 wraps a -10..-1 difference back to 0..9.
      alu_dig = alu_cy ? (alu_raw[3:0] + 4'd10) : alu_raw[3:0];
    end else begin
      alu_raw = {1'b0, alu_x} + {1'b0, alu_y} + {4'd0, cy_q};
      alu_cy  = (alu_raw > 5'd9);
      alu_dig = alu_cy ? (alu_raw[3:0] - 4'd10) : alu_raw[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    opa_d   = opa_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    fresh_d = fresh_q;
    neg_d   = neg_q;
    err_d   = err_q;
    cy_d    = cy_q;
    case (state_q)
      S_IDLE: begin
        idx_d = 3'd0;
        if (cmd_valid) begin
          if (cmd == 4'd15) begin
            buf_d   = 32'd0;
            opa_d   = 32'd0;
            op_d    = OP_NONE;
            cnt_d   = 4'd0;
            neg_d   = 1'b0;
            err_d   = 1'b0;
            fresh_d = 1'b0;
            state_d = S_REFRESH;
          end else if (!err_q) begin
            if (cmd <= 4'd9) begin
              // A full buffer can only be hit when not fresh.
              if (cnt_eff != 4'd8) begin
                fresh_d = 1'b0;
                if (fresh_q) neg_d = 1'b0;
                if (cnt_eff == 4'd0 && cmd == 4'd0) begin
                  buf_d = 32'd0;
                  cnt_d = 4'd0;
                end else begin
                  buf_d = {buf_eff[27:0], cmd};
                  cnt_d = cnt_eff + 4'd1;
                end
                state_d = S_REFRESH;
              end
            end else if (cmd == 4'd10 || cmd == 4'd11) begin
              opa_d   = buf_q;
              op_d    = (cmd == 4'd10) ? OP_ADD : OP_SUB;
              fresh_d = 1'b1;
            end else if (cmd == 4'd14 && op_q != OP_NONE) begin
              b_d     = buf_q;
              cy_d    = 1'b0;
              state_d = S_CALC;
            end
          end
        end
      end
      S_REFRESH: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_IDLE;
      end
      S_CALC: begin
        buf_d[nib +: 4] = alu_dig;
        cy_d  = alu_cy;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          if (op_q == OP_SUB && alu_cy) begin
            // opa < b: redo as b - opa to get the magnitude.
            cy_d    = 1'b0;
            state_d = S_CALC2;
          end else begin
            // An add or a non-borrowing subtract is never negative.
            neg_d = 1'b0;
            if (op_q == OP_ADD && alu_cy) begin
              err_d = 1'b1;
              buf_d = 32'd0;
            end
            op_d    = OP_NONE;
            fresh_d = 1'b1;
            state_d = S_REFRESH;
          end
        end
      end
      S_CALC2: begin
        buf_d[nib +: 4] = alu_dig;
        cy_d  = alu_cy;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          neg_d   = 1'b1;
          op_d    = OP_NONE;
          fresh_d = 1'b1;
          state_d = S_REFRESH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      idx_q   <= 3'd0;
      buf_q   <= 32'd0;
      opa_q   <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= 4'd0;
      fresh_q <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      opa_q   <= opa_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      fresh_q <= fresh_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      cy_q    <= cy_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_en     = (state_q == S_REFRESH);
  assign wr_pos    = wr_en ? {1'b0, idx_q} : 4'd0;
  assign wr_dig    = wr_en ? buf_q[nib +: 4] : 4'd0;
  assign neg       = neg_q;
  assign err       = err_q;

endmodule

// File: tb/tb_calc_seq.sv
// tb/tb_calc_seq.sv - self-checking bench for calc_seq: vector table, reset abort, random vs model
module tb_calc_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd = 4'd0;
  logic       cmd_ready, wr_en, neg, err;
  logic [3:0] wr_pos, wr_dig;

  calc_seq dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_ready(cmd_ready), .wr_en(wr_en), .wr_pos(wr_pos), .wr_dig(wr_dig),
    .neg(neg), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] c;
    int lat;
    int nwr;
    int disp;
    int neg;
    int err;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;
  int step_id = 0;

  int shadow[8];
  int got_lat, got_nwr, got_disp, got_stable, got_pos_ok;
  int f_neg, f_err;

  // Behavioural model: plain decimal integers.
  int m_buf, m_opa, m_op, m_cnt, m_fresh, m_neg, m_err;
  int e_lat, e_nwr;

  function void add(input logic [3:0] c, input int lat, input int nwr,
                    input int disp, input int n, input int e);
    vec_t v;
    v.c = c; v.lat = lat; v.nwr = nwr; v.disp = disp; v.neg = n; v.err = e;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, step_id, act, exp);
    end
  endtask

  task automatic wait_ready();
    int ok = 0;
    for (int k = 0; k < 60; k++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clock);
    end
    if (ok == 0) chk("ready_timeout", 0, 1);
  endtask

  // Called at a negedge with cmd_ready high; returns at the negedge where
  // cmd_ready is seen high again (or after the cycle budget).
  task automatic press(input logic [3:0] c);
    got_lat = 0; got_nwr = 0; got_stable = 1; got_pos_ok = 1;
    f_neg = 0; f_err = 0;
    cmd = c; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (cmd_ready) begin got_lat = k; break; end
      if (wr_en) begin
        if (int'(wr_pos) != got_nwr) got_pos_ok = 0;
        if (got_nwr == 0) begin
          f_neg = int'(neg); f_err = int'(err);
        end else if (int'(neg) != f_neg || int'(err) != f_err) begin
          got_stable = 0;
        end
        shadow[wr_pos[2:0]] = int'(wr_dig);
        got_nwr++;
      end
      @(negedge clock);
    end
    got_disp = 0;
    for (int p = 7; p >= 0; p--) got_disp = got_disp * 10 + shadow[p];
  endtask

  task automatic compare(input int lat, input int nwr, input int disp,
                         input int n, input int e);
    chk("latency", got_lat, lat);
    chk("writes", got_nwr, nwr);
    if (nwr > 0) begin
      chk("display", got_disp, disp);
      chk("pos_order", got_pos_ok, 1);
      chk("flag_stable", got_stable, 1);
      chk("neg_at_sweep", f_neg, n);
      chk("err_at_sweep", f_err, e);
    end
    chk("neg", int'(neg), n);
    chk("err", int'(err), e);
    step_id++;
  endtask

  task automatic model_step(input int c);
    e_lat = 1; e_nwr = 0;
    if (c == 15) begin
      m_buf = 0; m_opa = 0; m_op = 0; m_cnt = 0; m_neg = 0; m_err = 0; m_fresh = 0;
      e_lat = 9; e_nwr = 8;
    end else if (m_err != 0) begin
      // accepted and dropped
    end else if (c <= 9) begin
      if (m_fresh != 0) begin
        m_buf = 0; m_cnt = 0; m_fresh = 0; m_neg = 0;
      end
      if (m_cnt < 8) begin
        if (!(m_cnt == 0 && c == 0)) begin
          m_buf = m_buf * 10 + c;
          m_cnt++;
        end
        e_lat = 9; e_nwr = 8;
      end
    end else if (c == 10 || c == 11) begin
      m_opa = m_buf; m_op = c - 9; m_fresh = 1;
    end else if (c == 14 && m_op != 0) begin
      int r;
      if (m_op == 1) begin
        r = m_opa + m_buf;
        m_neg = 0;
        if (r > 99999999) begin m_err = 1; r = 0; end
        m_buf = r; e_lat = 17;
      end else begin
        r = m_opa - m_buf;
        if (r < 0) begin m_neg = 1; m_buf = -r; e_lat = 25; end
        else begin m_neg = 0; m_buf = r; e_lat = 17; end
      end
      e_nwr = 8; m_op = 0; m_fresh = 1;
    end
  endtask

  initial begin
    int v;
    int r;
    for (int p = 0; p < 8; p++) shadow[p] = 0;

    // Plan 1: 1, 2, 3
    add(4'd1, 9, 8, 1, 0, 0);
    add(4'd2, 9, 8, 12, 0, 0);
    add(4'd3, 9, 8, 123, 0, 0);
    // Plan 2: leading zeros, then 9th digit dropped
    add(4'd15, 9, 8, 0, 0, 0);
    add(4'd0, 9, 8, 0, 0, 0);
    add(4'd0, 9, 8, 0, 0, 0);
    v = 0;
    for (int d = 1; d <= 8; d++) begin
      v = v * 10 + d;
      add(4'(d), 9, 8, v, 0, 0);
    end
    add(4'd9, 1, 0, 0, 0, 0);
    // Plan 3: 45 + 78 = then + 7 =
    add(4'd15, 9, 8, 0, 0, 0);
    add(4'd4, 9, 8, 4, 0, 0);
    add(4'd5, 9, 8, 45, 0, 0);
    add(4'd10, 1, 0, 0, 0, 0);
    add(4'd7, 9, 8, 7, 0, 0);
    add(4'd8, 9, 8, 78, 0, 0);
    add(4'd14, 17, 8, 123, 0, 0);
    add(4'd10, 1, 0, 0, 0, 0);
    add(4'd7, 9, 8, 7, 0, 0);
    add(4'd14, 17, 8, 130, 0, 0);
    add(4'd12, 1, 0, 0, 0, 0);
    add(4'd14, 1, 0, 0, 0, 0);
    // Plan 4: 12 - 45 = then 5
    add(4'd15, 9, 8, 0, 0, 0);
    add(4'd1, 9, 8, 1, 0, 0);
    add(4'd2, 9, 8, 12, 0, 0);
    add(4'd11, 1, 0, 0, 0, 0);
    add(4'd4, 9, 8, 4, 0, 0);
    add(4'd5, 9, 8, 45, 0, 0);
    add(4'd14, 25, 8, 33, 1, 0);
    add(4'd5, 9, 8, 5, 0, 0);
    // Plan 5: 99999999 + 1 = overflow, ignored keys, clear
    add(4'd15, 9, 8, 0, 0, 0);
    v = 0;
    for (int d = 0; d < 8; d++) begin
      v = v * 10 + 9;
      add(4'd9, 9, 8, v, 0, 0);
    end
    add(4'd10, 1, 0, 0, 0, 0);
    add(4'd1, 9, 8, 1, 0, 0);
    add(4'd14, 17, 8, 0, 0, 1);
    add(4'd4, 1, 0, 0, 0, 1);
    add(4'd10, 1, 0, 0, 0, 1);
    add(4'd15, 9, 8, 0, 0, 0);

    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_pos", int'(wr_pos), 0);
    chk("rst_wr_dig", int'(wr_dig), 0);
    chk("rst_neg", int'(neg), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clock);
    chk("rst_no_refresh", int'(wr_en), 0);

    foreach (vq[i]) begin
      wait_ready();
      press(vq[i].c);
      compare(vq[i].lat, vq[i].nwr, vq[i].disp, vq[i].neg, vq[i].err);
    end

    // Plan 6: reset during the 3rd REFRESH cycle of a digit sweep
    wait_ready();
    cmd = 4'd5; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("abort_sweep_started", int'(wr_en), 1);
    @(negedge clock);
    @(negedge clock);
    chk("abort_third_pos", int'(wr_pos), 2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_neg", int'(neg), 0);
    press(4'd7);
    compare(9, 8, 7, 0, 0);

    // Random commands against the model
    press(4'd15);
    m_buf = 0; m_opa = 0; m_op = 0; m_cnt = 0; m_fresh = 0; m_neg = 0; m_err = 0;
    compare(9, 8, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      int c;
      r = int'($urandom_range(0, 99));
      if (r < 55)      c = int'($urandom_range(0, 9));
      else if (r < 65) c = 10;
      else if (r < 75) c = 11;
      else if (r < 88) c = 14;
      else if (r < 92) c = int'($urandom_range(12, 13));
      else if (r < 95) c = 15;
      else             c = 9;
      model_step(c);
      wait_ready();
      press(4'(c));
      compare(e_lat, e_nwr, m_buf, m_neg, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_seq.md
# calc_seq

Keystroke sequencer for the calculator. It accepts digit and operator commands, keeps the 8-digit BCD entry buffer and the pending operation, and evaluates add/subtract with a serial one-digit-per-cycle BCD ALU. It drives the display digit register (one `pos`/`dig` write per cycle), so every visible change reaches the 8 displays as an 8-cycle refresh sweep.

## Interface

No parameters. Digit count is fixed at 8 and BCD width at 4.

- `clock`  in  1  single system clock, all logic on its rising edge
- `reset`  in  1  synchronous, active-high
- `cmd_valid`  in  1  command strobe
- `cmd`  in  4  command code:
  - 0–9: digit
  - 10: add
  - 11: subtract
  - 14: equals
  - 15: clear
  - 12, 13: ignored
- `cmd_ready`  out  1  high only in IDLE
- `wr_en`  out  1  display write strobe
- `wr_pos`  out  4  display position, 0 = rightmost (least significant)
- `wr_dig`  out  4  BCD digit, always 0–9
- `neg`  out  1  last result was negative (magnitude is shown)
- `err`  out  1  add overflow occurred

## Operation

Internal state:
- `buf`: entry/result buffer, 8 BCD digits.
- `opa`: first operand, 8 BCD digits.
- `op`: pending operation, one of none/add/sub.
- `cnt`: number of entered digits, 0–8.
- `fresh`: the next digit starts a new number.

A command is accepted only when `cmd_valid && cmd_ready`. `cmd_valid` while not ready is dropped, not queued.

FSM states:
- IDLE: waits for an accepted command.
- REFRESH: 8 cycles. `wr_en` = 1, `wr_pos` counts 0..7, `wr_dig` = `buf[wr_pos]`. Returns to IDLE.
- CALC: 8 cycles, digit i = 0..7 per cycle.
  - Add: `buf[i] = opa[i] + b[i] + carry`, BCD-corrected.
  - Sub: `opa[i] − b[i] − borrow`, BCD-corrected.
  - `b` is the snapshot of `buf` taken at equals.
- CALC2: 8 cycles, `b − opa`. Entered only when a subtract ends CALC with a borrow out. Sets `neg` = 1.

Command effects in IDLE:
- Digit d:
  - If `fresh`: clear `buf`, set `cnt` = 0, `fresh` = 0, `neg` = 0.
  - If `cnt` = 8: ignored entirely, no refresh.
  - If `cnt` = 0 and d = 0: `buf` stays 0, go REFRESH.
  - Otherwise: `buf` = `{buf[6:0], d}`, `cnt`+1, go REFRESH.
- Add/sub: `opa` = `buf`, `op` = add/sub, `fresh` = 1, no refresh.
  - A second operator before equals only replaces `op`; there is no chained evaluation.
- Equals:
  - If `op` = none: ignored.
  - Otherwise go CALC. At the end: `op` = none, `fresh` = 1, go REFRESH. `buf` holds the result and can be used as `opa` by the next operator.
- Clear: `buf`, `opa`, `op`, `cnt`, `neg`, `err` all go to 0, `fresh` = 0, go REFRESH.
- While `err` = 1: every command except clear is accepted and ignored.

Arithmetic rules:
- Operands are unsigned 8-digit BCD.
- Add with carry out of digit 7: set `err` = 1, `buf` = 0, then REFRESH writes zeros.
- Sub result ≥ 0: `neg` = 0. Sub result < 0: CALC2 overwrites `buf` with the magnitude and sets `neg` = 1.

## Timing

Reset values (state IDLE):
- `cmd_ready` = 1
- `wr_en` = 0, `wr_pos` = 0, `wr_dig` = 0
- `neg` = 0, `err` = 0
- all internal registers = 0

Reset does not trigger a refresh.

Latency, with the command accepted in cycle T:
- Digit/clear: `wr_en` high T+1..T+8 (pos 0..7); `cmd_ready` high again at T+9.
- Equals, add or non-negative sub: CALC T+1..T+8, REFRESH T+9..T+16, ready at T+17.
- Equals, negative sub: CALC T+1..T+8, CALC2 T+9..T+16, REFRESH T+17..T+24, ready at T+25.
- Operator or ignored command: no writes; `cmd_ready` stays high, so back-to-back accepts are possible.

Flag timing:
- `neg` and `err` update in the cycle REFRESH starts and stay stable during the sweep.

Reset mid-operation:
- Reset in any state aborts it: `wr_en` = 0 in the cycle after reset is sampled, and no partial result is committed.

## Test plan

1. Reset, then keys 1, 2, 3: three sweeps of 8 writes each. The last sweep writes pos0=3, pos1=2, pos2=1, pos3..7=0. `cmd_ready` is high 9 cycles after each key.
2. Keys 0, 0, then 1..9: the leading zeros keep `buf` = 0. The 9th digit (9) produces no `wr_en`, and the display holds 12345678.
3. 45 + 78 =: the final sweep writes 00000123 with `neg` = 0 and `err` = 0. `cmd_ready` returns 17 cycles after equals is accepted. A following `+ 7 =` shows 130.
4. 12 − 45 =: the sweep writes 00000033 with `neg` = 1, and ready returns at T+25. The next digit 5 clears `neg` and shows 5.
5. 99999999 + 1 =: `err` = 1 and the sweep writes all zeros. A following digit 4 and `+` produce no writes. Clear gives `err` = 0 and 8 writes of 0.
6. Reset asserted in the 3rd REFRESH cycle: `wr_en` = 0 on the next cycle and `cmd_ready` = 1. The next key 7 sweeps 00000007.
